variable_nodes_seq: RTL and testbench

- Parametrised, time-multiplexed successor to the odd-layer variable-node stage of the neural min-sum LDPC decoder.
- Walks the edge list serially, grouped by variable node. For each variable it computes total = channel LLR + weighted incoming check messages, then emits extrinsic messages (total minus own edge) with saturation.
- Also produces per-variable hard decisions.
- Sits between the check-node (even) layer and the next check-node layer, or the decision output.

---
 rtl/vn_pkg.sv | 69 ++++++
 rtl/vn_edge_weight.sv | 32 +++
 rtl/variable_nodes_seq.sv | 210 +++++++++++++++++++++
 tb/tb_variable_nodes_seq.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vn_pkg.sv
// Shared definitions for the time-multiplexed variable-node stage:
// FSM state encoding, accumulator sizing, symmetric saturation and the
// degree-table sanity check used at elaboration.
package vn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } vn_state_t;

    // Upper bound on the packed degree table handed to deg_table_ok.
    localparam int MAX_TBL_BITS = 4096;

    // Accumulator width: one scaled term, headroom for DV_MAX+1 addends
    // (channel LLR plus every incoming message) and a sign bit.
    function automatic int acc_width(input int width, input int wgt_w,
                                     input int wgt_frac, input int dv_max);
        return width + wgt_w - wgt_frac + $clog2(dv_max + 1) + 1;
    endfunction

    // Clamp to the symmetric range +/-(2^(width-1)-1); the most negative
    // code is never produced so negation downstream cannot overflow.
    function automatic logic signed [63:0] sat_sym(input logic signed [63:0] x,
                                                   input int width);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< (width - 1)) - 64'sd1;
        if (x > lim) begin
            return lim;
        end
        if (x < -lim) begin
            return -lim;
        end
        return x;
    endfunction

    // Every degree entry must lie in 1..dv_max and the entries must add up
    // to the edge count, otherwise the serial edge walk would desynchronise.
    function automatic bit deg_table_ok(input logic [MAX_TBL_BITS-1:0] tbl,
                                        input int n_v, input int deg_w,
                                        input int dv_max, input int e);
        int                      sum;
        int                      d;
        bit                      ok;
        logic [MAX_TBL_BITS-1:0] sh;
        sum = 0;
        ok  = 1'b1;
        if (n_v * deg_w > MAX_TBL_BITS) begin
            return 1'b0;
        end
        for (int v = 0; v < n_v; v++) begin
            sh = tbl >> (v * deg_w);
            d  = 0;
            for (int i = 0; i < deg_w; i++) begin
                d = d | (int'(sh[i]) << i);
            end
            if (d < 1 || d > dv_max) begin
                ok = 1'b0;
            end
            sum = sum + d;
        end
        if (sum != e) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/vn_edge_weight.sv
// Combinational per-edge message scaling: term = floor(msg * weight / 2^WGT_FRAC).
// Build option: VN_WEIGHTS_EN enables the multiplier; without it the raw
// message is passed through (sign-extended) and the weight is ignored.
module vn_edge_weight #(
    parameter int WIDTH    = 8,
    parameter int WGT_W    = 8,
    parameter int WGT_FRAC = 6,
    parameter int TERM_W   = WIDTH + WGT_W + 1 - WGT_FRAC
) (
    input  logic [WIDTH-1:0]         msg,
    input  logic [WGT_W-1:0]         weight,
    output logic signed [TERM_W-1:0] term
);

`ifdef VN_WEIGHTS_EN
    localparam int PROD_W = WIDTH + WGT_W + 1;

    logic signed [PROD_W-1:0] prod;

    // Weight is unsigned, so it gets a zero guard bit before the signed multiply.
    assign prod = PROD_W'($signed(msg)) * PROD_W'($signed({1'b0, weight}));
    // Dropping the low WGT_FRAC bits of a two's-complement product is the
    // arithmetic right shift, i.e. rounding toward minus infinity.
    assign term = prod[PROD_W-1:WGT_FRAC];
`else
    logic unused_weight;

    assign term          = TERM_W'($signed(msg));
    assign unused_weight = ^weight;
`endif

endmodule

// File: rtl/variable_nodes_seq.sv
// Serial variable-node stage of the neural min-sum LDPC decoder.
// Walks the edge list grouped by variable: accumulates channel LLR plus the
// (optionally weighted) check messages, then emits saturated extrinsics.
// Build option: VN_WEIGHTS_EN (per-edge weights applied in vn_edge_weight).
module variable_nodes_seq
    import vn_pkg::*;
#(
    parameter int                    WIDTH    = 8,
    parameter int                    N_V      = 44,
    parameter int                    E        = 147,
    parameter int                    DV_MAX   = 6,
    parameter int                    DEG_W    = 3,
    parameter logic [N_V*DEG_W-1:0]  VAR_DEG  = '0,
    parameter int                    WGT_W    = 8,
    parameter int                    WGT_FRAC = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_ready,
    input  logic                 prev_ready,
    input  logic [WIDTH*N_V-1:0] all_llrs,
    input  logic [WIDTH*E-1:0]   prev_proc_elem,
    input  logic [WGT_W*E-1:0]   weights,
    output logic [WIDTH*E-1:0]   proc_elem,
    output logic [N_V-1:0]       hard_bits,
    output logic                 busy,
    output logic                 varn_ready
);

    localparam int V_W    = (N_V > 1) ? $clog2(N_V) : 1;
    localparam int EDGE_W = $clog2(E + 1);
    localparam int TERM_W = WIDTH + WGT_W + 1 - WGT_FRAC;
    localparam int ACC_W  = acc_width(WIDTH, WGT_W, WGT_FRAC, DV_MAX);

    localparam logic [MAX_TBL_BITS-1:0] VAR_DEG_EXT =
        {{(MAX_TBL_BITS - N_V*DEG_W){1'b0}}, VAR_DEG};

    // Configuration checks resolved at elaboration.
    if (!deg_table_ok(VAR_DEG_EXT, N_V, DEG_W, DV_MAX, E)) begin : g_bad_deg_table
        $error("variable_nodes_seq: VAR_DEG entries must be 1..DV_MAX and sum to E");
    end
    if ((1 << DEG_W) <= DV_MAX) begin : g_bad_deg_w
        $error("variable_nodes_seq: DEG_W too narrow for DV_MAX");
    end

    vn_state_t               state_reg, state_next;
    logic [V_W-1:0]          v_reg, v_next;
    logic [DEG_W-1:0]        k_reg, k_next;
    logic [EDGE_W-1:0]       b_reg, b_next;
    logic signed [ACC_W-1:0] acc_reg, acc_next;
    logic [N_V-1:0]          hard_bits_reg;

    logic                    start;
    logic [DEG_W-1:0]        deg_cur;
    logic [EDGE_W-1:0]       edge_idx;
    logic [WIDTH-1:0]        msg_cur;
    logic [WGT_W-1:0]        wgt_cur;
    logic signed [TERM_W-1:0] term;
    logic signed [ACC_W-1:0] term_ext;
    logic [V_W:0]            llr_idx;
    logic [WIDTH-1:0]        llr_sel;
    logic signed [ACC_W-1:0] llr_ext;
    logic signed [ACC_W-1:0] diff;
    logic [WIDTH-1:0]        sat_val;
    logic                    hb_we;
    logic                    emit_we;

    assign start    = data_ready & prev_ready;
    assign deg_cur  = VAR_DEG[v_reg*DEG_W +: DEG_W];
    assign edge_idx = b_reg + EDGE_W'(k_reg);

    // Select the message and weight of the edge currently being visited.
    always_comb begin
        msg_cur = '0;
        wgt_cur = '0;
        if (edge_idx < EDGE_W'(E)) begin
            msg_cur = prev_proc_elem[edge_idx*WIDTH +: WIDTH];
            wgt_cur = weights[edge_idx*WGT_W +: WGT_W];
        end
    end

    vn_edge_weight #(
        .WIDTH    (WIDTH),
        .WGT_W    (WGT_W),
        .WGT_FRAC (WGT_FRAC),
        .TERM_W   (TERM_W)
    ) u_edge_weight (
        .msg    (msg_cur),
        .weight (wgt_cur),
        .term   (term)
    );

    assign term_ext = ACC_W'(term);

    // LLR preloaded into acc: variable 0 at start, otherwise the next variable.
    always_comb begin
        llr_idx = '0;
        llr_sel = '0;
        if (state_reg != IDLE) begin
            llr_idx = (V_W+1)'(v_reg) + (V_W+1)'(1);
        end
        if (llr_idx < (V_W+1)'(N_V)) begin
            llr_sel = all_llrs[llr_idx*WIDTH +: WIDTH];
        end
    end

    assign llr_ext = ACC_W'($signed(llr_sel));
    assign diff    = acc_reg - term_ext;
    assign sat_val = WIDTH'(sat_sym(64'(diff), WIDTH));

    // Next-state, counter and output decode for the edge walk.
    always_comb begin
        state_next = state_reg;
        v_next     = v_reg;
        k_next     = k_reg;
        b_next     = b_reg;
        acc_next   = acc_reg;
        hb_we      = 1'b0;
        emit_we    = 1'b0;
        busy       = 1'b0;
        varn_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ACCUM;
                    v_next     = '0;
                    k_next     = '0;
                    b_next     = '0;
                    acc_next   = llr_ext;
                end
            end
            ACCUM: begin
                busy     = 1'b1;
                acc_next = acc_reg + term_ext;
                if (k_reg == deg_cur - DEG_W'(1)) begin
                    hb_we      = 1'b1;
                    k_next     = '0;
                    state_next = EMIT;
                end else begin
                    k_next = k_reg + DEG_W'(1);
                end
            end
            EMIT: begin
                busy    = 1'b1;
                emit_we = 1'b1;
                if (k_reg == deg_cur - DEG_W'(1)) begin
                    k_next = '0;
                    if (v_reg == V_W'(N_V - 1)) begin
                        state_next = DONE;
                    end else begin
                        v_next     = v_reg + V_W'(1);
                        b_next     = b_reg + EDGE_W'(deg_cur);
                        acc_next   = llr_ext;
                        state_next = ACCUM;
                    end
                end else begin
                    k_next = k_reg + DEG_W'(1);
                end
            end
            DONE: begin
                varn_ready = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, counters, accumulator and hard decisions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            v_reg         <= '0;
            k_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            hard_bits_reg <= '0;
        end else begin
            state_reg <= state_next;
            v_reg     <= v_next;
            k_reg     <= k_next;
            b_reg     <= b_next;
            acc_reg   <= acc_next;
            if (hb_we) begin
                hard_bits_reg[v_reg] <= acc_next[ACC_W-1];
            end
        end
    end

    assign hard_bits = hard_bits_reg;

    // One output register per edge; written only while its edge is emitted,
    // so edges not yet visited keep their previous-pass value.
    for (genvar gi = 0; gi < E; gi++) begin : g_edge
        logic [WIDTH-1:0] pe_reg;

        // Capture the saturated extrinsic for this edge.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pe_reg <= '0;
            end else if (emit_we && edge_idx == EDGE_W'(gi)) begin
                pe_reg <= sat_val;
            end
        end

        assign proc_elem[gi*WIDTH +: WIDTH] = pe_reg;
    end

endmodule

// File: tb/tb_variable_nodes_seq.sv
// Directed self-checking bench for variable_nodes_seq.
// Two instances share stimulus: dut_a with degrees {2,2,2}, dut_b with {1,2,3}.
module tb_variable_nodes_seq;

    logic        clk;
    logic        rst;
    logic        data_ready;
    logic        prev_ready;
    logic [23:0] all_llrs;
    logic [47:0] prev_proc_elem;
    logic [47:0] weights;
    logic [47:0] pe_a, pe_b;
    logic [2:0]  hb_a, hb_b;
    logic        busy_a, busy_b;
    logic        vr_a, vr_b;

    int n_tests = 0;
    int n_fail  = 0;

    int llr [3];
    int msg [6];
    int wgt [6];
    int exp_a [6];
    int exp_b [6];
    int exp_hb_a;
    int exp_hb_b;

    variable_nodes_seq #(
        .WIDTH(8), .N_V(3), .E(6), .DV_MAX(6), .DEG_W(3),
        .VAR_DEG(9'd146), .WGT_W(8), .WGT_FRAC(6)
    ) dut_a (
        .clk(clk), .rst(rst), .data_ready(data_ready), .prev_ready(prev_ready),
        .all_llrs(all_llrs), .prev_proc_elem(prev_proc_elem), .weights(weights),
        .proc_elem(pe_a), .hard_bits(hb_a), .busy(busy_a), .varn_ready(vr_a)
    );

    variable_nodes_seq #(
        .WIDTH(8), .N_V(3), .E(6), .DV_MAX(6), .DEG_W(3),
        .VAR_DEG(9'd209), .WGT_W(8), .WGT_FRAC(6)
    ) dut_b (
        .clk(clk), .rst(rst), .data_ready(data_ready), .prev_ready(prev_ready),
        .all_llrs(all_llrs), .prev_proc_elem(prev_proc_elem), .weights(weights),
        .proc_elem(pe_b), .hard_bits(hb_b), .busy(busy_b), .varn_ready(vr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int pe_at(input logic [47:0] v, input int e);
        logic [7:0] b;
        b = v[e*8 +: 8];
        return int'($signed(b));
    endfunction

    function automatic int sat127(input int x);
        if (x > 127) return 127;
        if (x < -127) return -127;
        return x;
    endfunction

    task automatic apply_inputs();
        for (int v = 0; v < 3; v++) all_llrs[v*8 +: 8] = 8'(llr[v]);
        for (int e = 0; e < 6; e++) begin
            prev_proc_elem[e*8 +: 8] = 8'(msg[e]);
            weights[e*8 +: 8]        = 8'(wgt[e]);
        end
    endtask

    // Golden model with unit weights for both degree tables.
    task automatic model_unweighted();
        int dega [3];
        int degb [3];
        int base;
        int tot;
        dega = '{2, 2, 2};
        degb = '{1, 2, 3};
        exp_hb_a = 0;
        exp_hb_b = 0;
        base = 0;
        for (int v = 0; v < 3; v++) begin
            tot = llr[v];
            for (int k = 0; k < dega[v]; k++) tot += msg[base+k];
            for (int k = 0; k < dega[v]; k++) exp_a[base+k] = sat127(tot - msg[base+k]);
            if (tot < 0) exp_hb_a |= (1 << v);
            base += dega[v];
        end
        base = 0;
        for (int v = 0; v < 3; v++) begin
            tot = llr[v];
            for (int k = 0; k < degb[v]; k++) tot += msg[base+k];
            for (int k = 0; k < degb[v]; k++) exp_b[base+k] = sat127(tot - msg[base+k]);
            if (tot < 0) exp_hb_b |= (1 << v);
            base += degb[v];
        end
    endtask

    // Start one pass and report the cycle of varn_ready (-1 on timeout).
    task automatic run_pass(output int done_cyc);
        @(posedge clk); #1;
        data_ready = 1'b1;
        prev_ready = 1'b1;
        @(posedge clk); #1;
        data_ready = 1'b0;
        prev_ready = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (vr_a) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data_ready = 1'b0;
        prev_ready = 1'b0;
        all_llrs = '0;
        prev_proc_elem = '0;
        weights = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (pe_a !== 48'h0) begin n_fail++; $display("FAIL reset_pe_a got %h want 0", pe_a); end
        n_tests++; if (pe_b !== 48'h0) begin n_fail++; $display("FAIL reset_pe_b got %h want 0", pe_b); end
        n_tests++; if (hb_a !== 3'b000) begin n_fail++; $display("FAIL reset_hb got %b want 000", hb_a); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
        n_tests++; if (vr_a !== 1'b0) begin n_fail++; $display("FAIL reset_vr got %b want 0", vr_a); end
        rst = 1'b1;
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        int  want [6];
        logic exp_busy, exp_vr;
        want = '{14, 13, -3, -25, 1, 1};
        llr = '{10, -5, 0};
        msg = '{3, 4, -20, 2, 1, 1};
        wgt = '{64, 64, 64, 64, 64, 64};
        apply_inputs();
        @(posedge clk); #1;
        data_ready = 1'b1;
        prev_ready = 1'b1;
        @(posedge clk); #1;
        data_ready = 1'b0;
        prev_ready = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            exp_busy = (c <= 12);
            exp_vr   = (c == 13);
            n_tests++; if (busy_a !== exp_busy) begin n_fail++; $display("FAIL basic_busy cycle %0d got %b want %b", c, busy_a, exp_busy); end
            n_tests++; if (vr_a !== exp_vr) begin n_fail++; $display("FAIL basic_vr cycle %0d got %b want %b", c, vr_a, exp_vr); end
            @(posedge clk); #1;
        end
        for (int e = 0; e < 6; e++) begin
            n_tests++; if (pe_at(pe_a, e) !== want[e]) begin n_fail++; $display("FAIL basic_pe[%0d] got %0d want %0d", e, pe_at(pe_a, e), want[e]); end
        end
        n_tests++; if (hb_a !== 3'b010) begin n_fail++; $display("FAIL basic_hb got %b want 010", hb_a); end
        $display("[TB] basic pass checked");
    endtask

    task automatic test_saturation();
        int done;
        llr = '{10, -5, 0};
        msg = '{3, 4, -20, 2, 127, 127};
        apply_inputs();
        run_pass(done);
        n_tests++; if (done !== 13) begin n_fail++; $display("FAIL sat_hi_done got %0d want 13", done); end
        n_tests++; if (pe_at(pe_a, 4) !== 127) begin n_fail++; $display("FAIL sat_hi_pe4 got %0d want 127", pe_at(pe_a, 4)); end
        n_tests++; if (pe_at(pe_a, 5) !== 127) begin n_fail++; $display("FAIL sat_hi_pe5 got %0d want 127", pe_at(pe_a, 5)); end
        n_tests++; if (hb_a[2] !== 1'b0) begin n_fail++; $display("FAIL sat_hi_hb2 got %b want 0", hb_a[2]); end
        llr = '{10, -5, -128};
        msg = '{3, 4, -20, 2, -128, -128};
        apply_inputs();
        run_pass(done);
        n_tests++; if (done !== 13) begin n_fail++; $display("FAIL sat_lo_done got %0d want 13", done); end
        n_tests++; if (pe_at(pe_a, 4) !== -127) begin n_fail++; $display("FAIL sat_lo_pe4 got %0d want -127", pe_at(pe_a, 4)); end
        n_tests++; if (pe_at(pe_a, 5) !== -127) begin n_fail++; $display("FAIL sat_lo_pe5 got %0d want -127", pe_at(pe_a, 5)); end
        n_tests++; if (hb_a[2] !== 1'b1) begin n_fail++; $display("FAIL sat_lo_hb2 got %b want 1", hb_a[2]); end
        $display("[TB] saturation checked");
    endtask

    task automatic test_weights();
        int done;
        int want [6];
        logic [2:0] want_hb;
`ifdef VN_WEIGHTS_EN
        // v0: 3,4 -> 1,2; v1: -20,2 -> -10,1; v2: 1,-3 -> 0,-2 (floor)
        want    = '{12, 11, -4, -15, -2, 0};
        want_hb = 3'b110;
`else
        want    = '{14, 13, -3, -25, -3, 1};
        want_hb = 3'b110;
`endif
        llr = '{10, -5, 0};
        msg = '{3, 4, -20, 2, 1, -3};
        wgt = '{32, 32, 32, 32, 32, 32};
        apply_inputs();
        run_pass(done);
        n_tests++; if (done !== 13) begin n_fail++; $display("FAIL wgt_done got %0d want 13", done); end
        for (int e = 0; e < 6; e++) begin
            n_tests++; if (pe_at(pe_a, e) !== want[e]) begin n_fail++; $display("FAIL wgt_pe[%0d] got %0d want %0d", e, pe_at(pe_a, e), want[e]); end
        end
        n_tests++; if (hb_a !== want_hb) begin n_fail++; $display("FAIL wgt_hb got %b want %b", hb_a, want_hb); end
        wgt = '{64, 64, 64, 64, 64, 64};
        apply_inputs();
        $display("[TB] weights checked");
    endtask

    task automatic test_handshake();
        int   vr_cnt;
        logic exp_vr;
        int   want [6];
        want = '{14, 13, -3, -25, 1, 1};
        llr = '{10, -5, 0};
        msg = '{3, 4, -20, 2, 1, 1};
        apply_inputs();
        @(posedge clk); #1;
        data_ready = 1'b1;
        prev_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL hs_idle_busy cycle %0d got %b want 0", c, busy_a); end
        end
        prev_ready = 1'b1;
        @(posedge clk); #1;
        data_ready = 1'b0;
        prev_ready = 1'b0;
        vr_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            if (c == 4) begin
                data_ready = 1'b1;
                prev_ready = 1'b1;
            end
            if (c == 5) begin
                data_ready = 1'b0;
                prev_ready = 1'b0;
            end
            exp_vr = (c == 13);
            if (vr_a) vr_cnt++;
            n_tests++; if (vr_a !== exp_vr) begin n_fail++; $display("FAIL hs_vr cycle %0d got %b want %b", c, vr_a, exp_vr); end
            @(posedge clk); #1;
        end
        n_tests++; if (vr_cnt !== 1) begin n_fail++; $display("FAIL hs_vr_count got %0d want 1", vr_cnt); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL hs_final_busy got %b want 0", busy_a); end
        for (int e = 0; e < 6; e++) begin
            n_tests++; if (pe_at(pe_a, e) !== want[e]) begin n_fail++; $display("FAIL hs_pe[%0d] got %0d want %0d", e, pe_at(pe_a, e), want[e]); end
        end
        $display("[TB] handshake checked");
    endtask

    task automatic test_reset_mid();
        int done;
        int want [6];
        want = '{14, 13, -3, -25, 1, 1};
        @(posedge clk); #1;
        data_ready = 1'b1;
        prev_ready = 1'b1;
        @(posedge clk); #1;
        data_ready = 1'b0;
        prev_ready = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_tests++; if (pe_a !== 48'h0) begin n_fail++; $display("FAIL rmid_pe got %h want 0", pe_a); end
        n_tests++; if (hb_a !== 3'b000) begin n_fail++; $display("FAIL rmid_hb got %b want 000", hb_a); end
        n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy_a); end
        n_tests++; if (vr_a !== 1'b0) begin n_fail++; $display("FAIL rmid_vr got %b want 0", vr_a); end
        #2;
        rst = 1'b1;
        run_pass(done);
        n_tests++; if (done !== 13) begin n_fail++; $display("FAIL rmid_done got %0d want 13", done); end
        for (int e = 0; e < 6; e++) begin
            n_tests++; if (pe_at(pe_a, e) !== want[e]) begin n_fail++; $display("FAIL rmid_pe[%0d] got %0d want %0d", e, pe_at(pe_a, e), want[e]); end
        end
        n_tests++; if (hb_a !== 3'b010) begin n_fail++; $display("FAIL rmid_hb_after got %b want 010", hb_a); end
        $display("[TB] mid-pass reset checked");
    endtask

    task automatic test_irregular();
        int done;
        int vec_fail;
        wgt = '{64, 64, 64, 64, 64, 64};
        for (int n = 0; n < 200; n++) begin
            for (int v = 0; v < 3; v++) llr[v] = int'($urandom_range(0, 255)) - 128;
            for (int e = 0; e < 6; e++) msg[e] = int'($urandom_range(0, 255)) - 128;
            apply_inputs();
            model_unweighted();
            run_pass(done);
            vec_fail = n_fail;
            n_tests++; if (done !== 13) begin n_fail++; $display("FAIL irr_done vec %0d got %0d want 13", n, done); end
            n_tests++; if (vr_b !== 1'b1) begin n_fail++; $display("FAIL irr_vr_b vec %0d got %b want 1", n, vr_b); end
            for (int e = 0; e < 6; e++) begin
                n_tests++; if (pe_at(pe_b, e) !== exp_b[e]) begin n_fail++; $display("FAIL irr_pe_b[%0d] vec %0d got %0d want %0d", e, n, pe_at(pe_b, e), exp_b[e]); end
                n_tests++; if (pe_at(pe_a, e) !== exp_a[e]) begin n_fail++; $display("FAIL irr_pe_a[%0d] vec %0d got %0d want %0d", e, n, pe_at(pe_a, e), exp_a[e]); end
            end
            n_tests++; if (hb_b !== 3'(exp_hb_b)) begin n_fail++; $display("FAIL irr_hb_b vec %0d got %b want %b", n, hb_b, 3'(exp_hb_b)); end
            n_tests++; if (hb_a !== 3'(exp_hb_a)) begin n_fail++; $display("FAIL irr_hb_a vec %0d got %b want %b", n, hb_a, 3'(exp_hb_a)); end
            $display("[TB] random vec %0d llr %0d %0d %0d -> %s", n, llr[0], llr[1], llr[2],
                     (n_fail == vec_fail) ? "ok" : "bad");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_weights();
        test_handshake();
        test_reset_mid();
        test_irregular();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
